// File: rtl/trdb_packet_arbiter.sv
// Round-robin packet arbiter for the trace output port.
// Grants one whole packet at a time. The granted packet's bits above its
// length are zeroed, and the packet is then sent as WORD_LEN-bit words on a
// valid/ready stream, LSB word first.
module trdb_packet_arbiter #(
    parameter int NREQ       = 3,
    parameter int PACKET_LEN = 128,
    parameter int WORD_LEN   = 32,
    parameter int LENW       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*PACKET_LEN-1:0] req_bits_i,
    input  logic [NREQ*LENW-1:0]       req_len_i,
    output logic                       word_valid_o,
    input  logic                       word_ready_i,
    output logic [WORD_LEN-1:0]        word_o,
    output logic                       word_last_o,
    output logic                       busy_o,
    output logic [$clog2(NREQ)-1:0]    grant_idx_o
);

    localparam int IDXW = $clog2(NREQ);
    localparam logic [LENW-1:0] PKT_LEN_L = LENW'(PACKET_LEN);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDXW-1:0]         ptr_q, ptr_d;
    logic [IDXW-1:0]         gidx_q, gidx_d;
    logic [PACKET_LEN-1:0]   shreg_q, shreg_d;
    logic [LENW-1:0]         cnt_q, cnt_d;

    logic                    gnt_found;
    logic [IDXW-1:0]         gnt_idx;
    logic [PACKET_LEN-1:0]   sel_bits;
    logic [LENW-1:0]         sel_len;
    logic [LENW-1:0]         eff_len;
    logic [PACKET_LEN-1:0]   len_mask;
    logic [LENW-1:0]         nwords;
    logic                    grant;

    // Round-robin search: first valid requester starting just after the pointer.
    always_comb begin : p_pick
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDXW'(cand);
            end
        end
    end

    // Select the winner's packet, clamp its length and build the keep-mask.
    always_comb begin
        sel_bits = req_bits_i[int'(gnt_idx)*PACKET_LEN +: PACKET_LEN];
        sel_len  = req_len_i[int'(gnt_idx)*LENW +: LENW];
        eff_len  = (sel_len > PKT_LEN_L) ? PKT_LEN_L : sel_len;
        nwords   = LENW'((int'(eff_len) + WORD_LEN - 1) / WORD_LEN);
        len_mask = '0;
        for (int b = 0; b < PACKET_LEN; b++) begin
            len_mask[b] = (b < int'(eff_len));
        end
    end

    // A grant needs IDLE and no flush; the ready pulse is also held low while
    // in reset so no requester believes its packet was taken.
    always_comb begin
        grant       = rst_ni && (state_q == IDLE) && !flush_i && gnt_found;
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Next-state logic: capture on grant, shift out on handshake, abort on flush.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    ptr_d   = gnt_idx;
                    gidx_d  = gnt_idx;
                    shreg_d = sel_bits & len_mask;
                    cnt_d   = nwords;
                    // A zero-length packet is accepted but produces no words.
                    if (nwords != '0) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (word_ready_i) begin
                    shreg_d = shreg_q >> WORD_LEN;
                    cnt_d   = cnt_q - LENW'(1);
                end
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (word_ready_i && (cnt_q == LENW'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= IDXW'(NREQ - 1);
            gidx_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stream outputs are driven only in SEND; a flushed remainder never leaks.
    always_comb begin
        busy_o       = (state_q == SEND);
        word_valid_o = busy_o;
        word_o       = busy_o ? shreg_q[WORD_LEN-1:0] : '0;
        word_last_o  = busy_o && (cnt_q == LENW'(1));
        grant_idx_o  = gidx_q;
    end

endmodule

// File: tb/tb_trdb_packet_arbiter.sv
// Self-checking bench for trdb_packet_arbiter: a word-queue reference model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized phase.
module tb_trdb_packet_arbiter;

    localparam int NREQ = 3;
    localparam int PL   = 128;
    localparam int WL   = 32;
    localparam int LENW = 8;
    localparam int IDXW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 word_ready = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*PL-1:0]   req_bits = '0;
    logic [NREQ*LENW-1:0] req_len = '0;
    logic                 word_valid;
    logic [WL-1:0]        word;
    logic                 word_last;
    logic                 busy;
    logic [IDXW-1:0]      gidx;

    int checks = 0;
    int failures = 0;

    // Reference model state: words still to be sent for the current packet.
    logic [WL-1:0] mq[$];
    int            m_ptr = NREQ - 1;
    int            m_gidx = 0;

    // Observation logs used by the directed scenarios.
    logic [WL:0]   obs_words[$];
    int            obs_grants[$];

    always #5 clk = ~clk;

    trdb_packet_arbiter #(
        .NREQ(NREQ), .PACKET_LEN(PL), .WORD_LEN(WL), .LENW(LENW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .flush_i(flush),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_bits_i(req_bits),
        .req_len_i(req_len),
        .word_valid_o(word_valid),
        .word_ready_i(word_ready),
        .word_o(word),
        .word_last_o(word_last),
        .busy_o(busy),
        .grant_idx_o(gidx)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: check outputs against the model, log, then advance the model.
    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        logic [WL-1:0]   e_word;
        logic [PL-1:0]   pk;
        logic [WL-1:0]   w;
        int              g;
        int              L;
        bit              m_busy;
        if (!rst_n) begin
            mq.delete();
            m_ptr  = NREQ - 1;
            m_gidx = 0;
            chk("rst_word_valid", 64'(word_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_word_last", 64'(word_last), 64'(0));
            chk("rst_word", 64'(word), 64'(0));
            chk("rst_grant_idx", 64'(gidx), 64'(0));
        end else begin
            m_busy  = (mq.size() != 0);
            e_ready = '0;
            g       = -1;
            if (!m_busy && !flush) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) e_ready[g] = 1'b1;
            e_word = '0;
            if (m_busy) e_word = mq[0];
            chk("word_valid", 64'(word_valid), 64'(m_busy));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("word", 64'(word), 64'(e_word));
            chk("word_last", 64'(word_last), 64'(mq.size() == 1));
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("grant_idx", 64'(gidx), 64'(m_gidx));
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k]) obs_grants.push_back(k);
            end
            if (word_valid && word_ready) obs_words.push_back({word_last, word});
            if (m_busy) begin
                if (word_ready) void'(mq.pop_front());
                if (flush) mq.delete();
            end else if (g >= 0) begin
                m_ptr  = g;
                m_gidx = g;
                L = int'(req_len[g*LENW +: LENW]);
                if (L > PL) L = PL;
                pk = req_bits[g*PL +: PL];
                for (int wi = 0; wi * WL < L; wi++) begin
                    w = '0;
                    for (int b = 0; b < WL; b++) begin
                        if (wi * WL + b < L) w[b] = pk[wi*WL + b];
                    end
                    mq.push_back(w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input int len, input logic [PL-1:0] bits);
        req_valid[i]              = v;
        req_len[i*LENW +: LENW]   = LENW'(len);
        req_bits[i*PL +: PL]      = bits;
    endtask

    function automatic logic [PL-1:0] rnd_bits();
        logic [PL-1:0] r;
        for (int i = 0; i < PL / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Wait (bounded) for requester i to see its ready pulse, pass the grant edge, drop valid.
    task automatic wait_grant_drop(input int i);
        int n;
        n = 0;
        #1;
        while (!req_ready[i] && n < 50) begin
            tick();
            n++;
        end
        chk("grant_seen", 64'(req_ready[i]), 64'(1));
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_reached", 64'(busy), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PL-1:0] b3, b5, b1;
        logic [WL-1:0] hw;
        logic          hl;
        logic [WL:0]   exp1[3];
        int            n;

        repeat (3) tick();
        rst_n = 1'b1;
        word_ready = 1'b1;
        tick();

        // Scenario: all three requesters valid, one-word packets -> 0,1,2,0,1.
        obs_grants.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32, rnd_bits());
        n = 0;
        while (obs_grants.size() < 5 && n < 100) begin
            tick();
            n++;
        end
        req_valid = '0;
        chk("t2_grant_count", 64'(obs_grants.size() >= 5), 64'(1));
        for (int i = 0; i < 5 && i < obs_grants.size(); i++) begin
            chk("t2_grant_order", 64'(obs_grants[i]), 64'(i % 3));
        end
        tick();
        wait_idle();

        // Scenario: len=70 all-ones -> FFFFFFFF, FFFFFFFF, 0000003F.
        exp1[0] = {1'b0, 32'hFFFF_FFFF};
        exp1[1] = {1'b0, 32'hFFFF_FFFF};
        exp1[2] = {1'b1, 32'h0000_003F};
        obs_words.delete();
        set_req(0, 1'b1, 70, '1);
        wait_grant_drop(0);
        wait_idle();
        chk("t1_word_count", 64'(obs_words.size()), 64'(3));
        for (int i = 0; i < 3 && i < obs_words.size(); i++) chk("t1_word", 64'(obs_words[i]), 64'(exp1[i]));

        // Scenario: backpressure for 5 cycles after word 1 on a 4-word packet.
        obs_words.delete();
        b3 = rnd_bits();
        set_req(0, 1'b1, 128, b3);
        wait_grant_drop(0);
        tick();
        word_ready = 1'b0;
        hw = word;
        hl = word_last;
        chk("t3_held_word_value", 64'(hw), 64'(b3[63:32]));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stable_word", 64'(word), 64'(hw));
            chk("t3_stable_last", 64'(word_last), 64'(hl));
            chk("t3_stable_valid", 64'(word_valid), 64'(1));
        end
        word_ready = 1'b1;
        wait_idle();
        chk("t3_word_count", 64'(obs_words.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_words.size(); i++) begin
            chk("t3_word", 64'(obs_words[i]), 64'({i == 3, b3[i*32 +: 32]}));
        end

        // Scenario: len=0 is accepted and dropped; len=200 clamps to 4 words.
        obs_words.delete();
        obs_grants.delete();
        set_req(0, 1'b1, 0, rnd_bits());
        wait_grant_drop(0);
        tick();
        chk("t4_zero_busy", 64'(busy), 64'(0));
        chk("t4_zero_grants", 64'(obs_grants.size()), 64'(1));
        chk("t4_zero_words", 64'(obs_words.size()), 64'(0));
        set_req(0, 1'b1, 200, '1);
        wait_grant_drop(0);
        wait_idle();
        chk("t4_clamp_words", 64'(obs_words.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_words.size(); i++) begin
            chk("t4_clamp_word", 64'(obs_words[i]), 64'({i == 3, 32'hFFFF_FFFF}));
        end

        // Scenario: flush after two handshakes; pending req1 granted next cycle.
        obs_words.delete();
        b5 = rnd_bits();
        b1 = rnd_bits();
        set_req(0, 1'b1, 128, b5);
        wait_grant_drop(0);
        set_req(1, 1'b1, 32, b1);
        tick();
        tick();
        flush = 1'b1;
        word_ready = 1'b0;
        tick();
        flush = 1'b0;
        word_ready = 1'b1;
        #1;
        chk("t5_flush_busy", 64'(busy), 64'(0));
        chk("t5_flush_valid", 64'(word_valid), 64'(0));
        chk("t5_req1_ready", 64'(req_ready), 64'(3'b010));
        tick();
        req_valid[1] = 1'b0;
        wait_idle();
        chk("t5_word_count", 64'(obs_words.size()), 64'(3));
        if (obs_words.size() == 3) begin
            chk("t5_word0", 64'(obs_words[0]), 64'({1'b0, b5[31:0]}));
            chk("t5_word1", 64'(obs_words[1]), 64'({1'b0, b5[63:32]}));
            chk("t5_req1_word", 64'(obs_words[2]), 64'({1'b1, b1[31:0]}));
        end

        // Scenario: asynchronous reset mid-SEND, then req0 served first.
        word_ready = 1'b0;
        set_req(0, 1'b1, 128, rnd_bits());
        wait_grant_drop(0);
        set_req(2, 1'b1, 32, rnd_bits());
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(word_valid), 64'(0));
        chk("t6_async_busy", 64'(busy), 64'(0));
        chk("t6_async_ready", 64'(req_ready), 64'(0));
        tick();
        tick();
        set_req(0, 1'b1, 32, rnd_bits());
        word_ready = 1'b1;
        obs_grants.delete();
        rst_n = 1'b1;
        wait_grant_drop(0);
        chk("t6_first_grant_seen", 64'(obs_grants.size() >= 1), 64'(1));
        if (obs_grants.size() >= 1) chk("t6_first_grant", 64'(obs_grants[0]), 64'(0));
        req_valid = '0;
        tick();
        wait_idle();

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                int len;
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(1, 128);
                set_req(i, ($urandom_range(0, 2) != 0), len, rnd_bits());
            end
            word_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            tick();
        end
        req_valid  = '0;
        flush      = 1'b0;
        word_ready = 1'b1;
        tick();
        wait_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
